// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and driver-state encodings, default parameters.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_DATA_WIDTH     = 8;
  localparam int ALU_TIMEOUT_CYCLES = 16;

  // Two-bit ALU operation, sent LSB first over the serial opcode line.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PAR  = 2'b10,
    OP_COMP = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_A    = 3'd1,
    ST_SEND_B    = 3'd2,
    ST_COMMIT    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESP      = 3'd5
  } drv_state_e;

  // One spare bit above clog2 so the terminal count is always representable.
  function automatic int ctr_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/alu_timeout_ctr.sv
// Saturating wait counter; expired flags the last permitted waiting cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts only while enable is high, clear has priority.
module alu_timeout_ctr
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ALU_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = ctr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign expired = (r_count >= LIMIT);

  // Count waiting cycles; hold at the limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_driver.sv
// Serialises one request onto the ALU opcode/data bus and returns its result.
// Latency: accept -> first opcode_valid 1 cycle; done -> rsp_valid 1 cycle.
// Backpressure: single outstanding; req_ready only in IDLE, RESP held until rsp_ready.
module alu_driver
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = ALU_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout
);

  drv_state_e            r_state;
  drv_state_e            w_next;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_overflow;
  logic                  r_rsp_timeout;
  logic                  w_accept;
  logic                  w_expired;
  logic                  w_ctr_clear;
  logic                  w_ctr_en;

  // Not ready while reset is held, even though the state is already IDLE.
  assign req_ready   = (r_state == ST_IDLE) && !reset;
  assign w_accept    = req_valid && req_ready;
  assign w_ctr_clear = (r_state == ST_COMMIT);
  assign w_ctr_en    = (r_state == ST_WAIT_DONE) && !done;

  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_timeout  = r_rsp_timeout;

  alu_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_ctr_clear),
    .enable (w_ctr_en),
    .expired(w_expired)
  );

  // State register; reset abandons any transaction without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the request on acceptance so upstream may change its bus afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= req_op;
      r_a  <= req_a;
      r_b  <= req_b;
    end
  end

  // Capture the response when leaving WAIT_DONE; done beats a coincident timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_timeout  <= 1'b0;
    end else if (r_state == ST_WAIT_DONE) begin
      if (done) begin
        r_rsp_result   <= result;
        r_rsp_overflow <= overflow;
        r_rsp_timeout  <= 1'b0;
      end else if (w_expired) begin
        r_rsp_result   <= '0;
        r_rsp_overflow <= 1'b0;
        r_rsp_timeout  <= 1'b1;
      end
    end
  end

  // Next state and ALU-side bus; the bus idles at zero outside the three send beats.
  always_comb begin
    w_next       = r_state;
    opcode_valid = 1'b0;
    opcode       = 1'b0;
    data         = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SEND_A;
      end
      ST_SEND_A: begin
        opcode_valid = 1'b1;
        opcode       = r_op[0];
        data         = r_a;
        w_next       = ST_SEND_B;
      end
      ST_SEND_B: begin
        opcode_valid = 1'b1;
        opcode       = r_op[1];
        data         = r_b;
        w_next       = ST_COMMIT;
      end
      ST_COMMIT: begin
        opcode_valid = 1'b1;
        w_next       = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done || w_expired) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a per-cycle expectation queue and ALU stand-in.
// Latency: expectations are queued for each cycle and checked on the falling edge.
// Backpressure: rsp_ready holds and req_valid-while-busy are exercised directly.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          opcode_valid;
  logic          opcode;
  logic [DW-1:0] data;
  logic          done;
  logic [DW-1:0] result;
  logic          overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;

  alu_driver #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .opcode_valid(opcode_valid),
    .opcode      (opcode),
    .data        (data),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic          opv;
    logic          opc;
    logic [DW-1:0] dat;
    logic          rv;
    logic          chk_rsp;
    logic [DW-1:0] res;
    logic          ovf;
    logic          to;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] seen_res;
  logic          seen_ovf;
  logic          seen_to;

  always @(posedge clk) cyc++;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Stand-in ALU: returns {overflow, result} from plain arithmetic.
  function automatic logic [DW:0] alu_ref(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), a - b};
      2'b10:   r = {1'b0, 7'd0, ^{a, b}};
      default: r = {1'b0, 7'd0, (a > b)};
    endcase
    return r;
  endfunction

  // Single compare process: every queued cycle is checked on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk1("req_ready", req_ready, cur.rdy);
      chk1("opcode_valid", opcode_valid, cur.opv);
      chk1("opcode", opcode, cur.opc);
      chk8("data", data, cur.dat);
      chk1("rsp_valid", rsp_valid, cur.rv);
      if (cur.chk_rsp) begin
        chk8("rsp_result", rsp_result, cur.res);
        chk1("rsp_overflow", rsp_overflow, cur.ovf);
        chk1("rsp_timeout", rsp_timeout, cur.to);
      end
      if (rsp_valid === 1'b1) begin
        seen_res = rsp_result;
        seen_ovf = rsp_overflow;
        seen_to  = rsp_timeout;
      end
    end
  end

  // Queue the expectation for the current cycle, then advance to the next one.
  task automatic tick(input logic rdy, input logic opv, input logic opc, input logic [DW-1:0] dat,
                      input logic rv, input logic chk_rsp, input logic [DW-1:0] res,
                      input logic ovf, input logic to);
    exp_t e;
    e.rdy = rdy; e.opv = opv; e.opc = opc; e.dat = dat; e.rv = rv;
    e.chk_rsp = chk_rsp; e.res = res; e.ovf = ovf; e.to = to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic stray_done);
    req_valid = 1'b0;
    done      = stray_done;
    result    = 8'h77;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    done = 1'b0;
  endtask

  // One full transaction. dly < 0 means the ALU never answers.
  task automatic run_txn(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int dly, input int hold, input bit stray, input bit keep);
    logic [DW:0]   m;
    logic          eto;
    logic [DW-1:0] eres;
    logic          eovf;
    int            nw;
    m    = alu_ref(op, a, b);
    eto  = (dly < 0);
    eres = eto ? '0 : m[DW-1:0];
    eovf = eto ? 1'b0 : m[DW];
    nw   = eto ? 16 : dly + 1;

    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; done = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    req_valid = keep; req_op = ~op; req_a = 8'hEE; req_b = 8'hDD;
    tick(1'b0, 1'b1, op[0], a, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, op[1], b, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int w = 0; w < nw; w++) begin
      done     = (w == dly);
      result   = done ? m[DW-1:0] : 8'hA5;
      overflow = done ? m[DW] : 1'b1;
      tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    done = 1'b0; result = 8'h5A; overflow = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      done      = stray && (h < hold);
      tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, eres, eovf, eto);
    end
    rsp_ready = 1'b0; done = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    done = 1'b0; result = '0; overflow = 1'b0; rsp_ready = 1'b0;
    seen_res = '0; seen_ovf = 1'b0; seen_to = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: nothing ready, everything at zero.
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b0);

    // ADD 12+34, done on third waiting cycle.
    run_txn(2'b00, 8'h12, 8'h34, 2, 0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    chk8("add_lit_res", seen_res, 8'h46);
    chk1("add_lit_ovf", seen_ovf, 1'b0);

    // SUB 05-03: opcode bits 1 then 0.
    run_txn(2'b01, 8'h05, 8'h03, 1, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk8("sub_lit_res", seen_res, 8'h02);

    // ADD FF+01 wraps with overflow.
    run_txn(2'b00, 8'hFF, 8'h01, 0, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk8("ovf_lit_res", seen_res, 8'h00);
    chk1("ovf_lit_ovf", seen_ovf, 1'b1);

    // No done at all: response 16 cycles after entering WAIT_DONE.
    run_txn(2'b00, 8'h03, 8'h04, -1, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk1("timeout_lit_to", seen_to, 1'b1);
    chk8("timeout_lit_res", seen_res, 8'h00);

    // Response held 5 cycles with req_valid high and stray done pulses.
    run_txn(2'b00, 8'h21, 8'h10, 3, 5, 1'b1, 1'b1);
    idle_cycle(1'b1);
    chk8("hold_lit_res", seen_res, 8'h31);

    // done on the same cycle the timeout would fire: done wins.
    run_txn(2'b01, 8'h09, 8'h04, 15, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk1("race_lit_to", seen_to, 1'b0);
    chk8("race_lit_res", seen_res, 8'h05);

    // COMP: opcode bits 1,1.
    run_txn(2'b11, 8'hF0, 8'h0F, 0, 1, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk8("comp_lit_res", seen_res, 8'h01);

    // Reset during SEND_B aborts, clears captured response.
    req_valid = 1'b1; req_op = 2'b10; req_a = 8'h3C; req_b = 8'hC3;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    req_valid = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Recovery after the abort.
    run_txn(2'b10, 8'h01, 8'h00, 4, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk8("par_lit_res", seen_res, 8'h01);

    @(negedge clk);
    #1;
    chk1("queue_drained", (exp_q.size() == 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
